// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one bus request per aligned access, with the pipeline
// stalled until the response has been retired through the DONE state.
module mem_lsu #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemReadM,
  input  logic            MemWriteM,
  input  logic [2:0]      funct3M,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic [XLEN-1:0] dmem_addr,
  output logic            dmem_we,
  output logic [3:0]      dmem_wstrb,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_rsp_valid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [XLEN-1:0] ReadDataM,
  output logic            StallM,
  output logic            MisalignM
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t          state;
  logic            access;
  logic            misalign;
  logic [3:0]      st_strb;
  logic [XLEN-1:0] st_data;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;

  logic [XLEN-1:0] addr_q;
  logic            we_q;
  logic [3:0]      strb_q;
  logic [XLEN-1:0] wdata_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [XLEN-1:0] load_q;

  always_comb begin
    access   = MemReadM | MemWriteM;
    misalign = 1'b0;
    case (funct3M[1:0])
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = ALUResultM[0];
      default: misalign = |ALUResultM[1:0];
    endcase
  end

  always_comb begin
    st_strb = '0;
    st_data = '0;
    if (MemWriteM) begin
      case (funct3M[1:0])
        2'b00: begin
          st_strb = 4'b0001 << ALUResultM[1:0];
          st_data = {4{WriteDataM[7:0]}};
        end
        2'b01: begin
          st_strb = 4'b0011 << ALUResultM[1:0];
          st_data = {2{WriteDataM[15:0]}};
        end
        default: begin
          st_strb = 4'b1111;
          st_data = WriteDataM;
        end
      endcase
    end
  end

  // Extraction uses the offset and size latched at issue, not the live MEM inputs.
  always_comb begin
    ld_byte = dmem_rdata[7:0];
    case (off_q)
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      2'd3:    ld_byte = dmem_rdata[31:24];
      default: ld_byte = dmem_rdata[7:0];
    endcase
    ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      strb_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      load_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (access && !misalign) begin
            addr_q  <= {ALUResultM[XLEN-1:2], 2'b00};
            we_q    <= MemWriteM;
            strb_q  <= st_strb;
            wdata_q <= st_data;
            f3_q    <= funct3M;
            off_q   <= ALUResultM[1:0];
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (dmem_req_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (dmem_rsp_valid) begin
            load_q <= ld_data;
            state  <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stall and misalign must react to the access in the same cycle it appears.
  always_comb begin
    dmem_req_valid = !reset && (state == S_REQ);
    dmem_addr      = addr_q;
    dmem_we        = we_q & ~reset;
    dmem_wstrb     = reset ? 4'b0000 : strb_q;
    dmem_wdata     = wdata_q;
    StallM         = !reset && (((state == S_IDLE) && access && !misalign) ||
                                (state == S_REQ) || (state == S_WAIT));
    MisalignM      = !reset && (state == S_IDLE) && access && misalign;
    ReadDataM      = (!reset && (state == S_DONE) && !we_q) ? load_q : '0;
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: transaction-level reference model checked every cycle,
// directed accesses with hand-computed results, then randomized traffic.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic        dmem_req_valid, dmem_req_ready;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rdata;
  logic [31:0] ReadDataM;
  logic        StallM, MisalignM;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  mem_lsu #(.XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .funct3M(funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wstrb(dmem_wstrb),
    .dmem_wdata(dmem_wdata), .dmem_rsp_valid(dmem_rsp_valid),
    .dmem_rdata(dmem_rdata), .ReadDataM(ReadDataM),
    .StallM(StallM), .MisalignM(MisalignM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit is_mis(input logic [2:0] f3, input logic [31:0] a);
    return (int'(a[1:0]) % size_of(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_lanes(input logic [2:0] f3, input logic [31:0] a);
    int s = size_of(f3);
    int mask = ((1 << s) - 1) << int'(a[1:0]);
    return 4'(mask);
  endfunction

  function automatic logic [31:0] m_store(input logic [2:0] f3, input logic [31:0] wd);
    case (size_of(f3))
      1:       return (wd & 32'hFF) * 32'h01010101;
      2:       return (wd & 32'hFFFF) * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input int off, input logic [31:0] rd);
    int s = size_of(f3);
    longint v = longint'(rd >> (8 * off));
    if (s < 4) begin
      v = v % (longint'(1) << (8 * s));
      if (!f3[2] && v >= (longint'(1) << (8 * s - 1))) v = v - (longint'(1) << (8 * s));
    end
    return 32'(v);
  endfunction

  typedef enum int {M_IDLE, M_ISSUE, M_AWAIT, M_RETIRE} mphase_t;
  mphase_t     ph = M_IDLE;
  logic [31:0] m_addr = '0, m_wdata = '0, m_result = '0;
  logic        m_we = 1'b0;
  logic [3:0]  m_strb = '0;
  logic [2:0]  m_f3 = '0;
  int          m_off = 0;

  always @(posedge clk) begin
    if (reset) begin
      ph <= M_IDLE; m_addr <= '0; m_we <= 1'b0; m_strb <= '0; m_wdata <= '0; m_result <= '0;
    end else begin
      case (ph)
        M_IDLE:
          if ((MemReadM || MemWriteM) && !is_mis(funct3M, ALUResultM)) begin
            m_addr  <= ALUResultM & ~32'h3;
            m_we    <= MemWriteM;
            m_strb  <= MemWriteM ? m_lanes(funct3M, ALUResultM) : 4'b0000;
            m_wdata <= MemWriteM ? m_store(funct3M, WriteDataM) : 32'h0;
            m_f3    <= funct3M;
            m_off   <= int'(ALUResultM[1:0]);
            ph      <= M_ISSUE;
          end
        M_ISSUE:  if (dmem_req_ready) ph <= M_AWAIT;
        M_AWAIT:
          if (dmem_rsp_valid) begin
            m_result <= m_we ? 32'h0 : m_load(m_f3, m_off, dmem_rdata);
            ph       <= M_RETIRE;
          end
        default:  ph <= M_IDLE;
      endcase
    end
  end

  logic acc, misal, e_valid, e_stall, e_mis;
  logic [31:0] e_rd;

  always @(negedge clk) begin
    #2;
    if (cmp_en) begin
      acc     = MemReadM | MemWriteM;
      misal   = acc && is_mis(funct3M, ALUResultM);
      e_valid = !reset && ph == M_ISSUE;
      e_stall = !reset && ((ph == M_IDLE && acc && !misal) || ph == M_ISSUE || ph == M_AWAIT);
      e_mis   = !reset && ph == M_IDLE && misal;
      e_rd    = (!reset && ph == M_RETIRE) ? m_result : 32'h0;
      chk("cyc_valid", 32'(dmem_req_valid), 32'(e_valid));
      chk("cyc_stall", 32'(StallM), 32'(e_stall));
      chk("cyc_misalign", 32'(MisalignM), 32'(e_mis));
      chk("cyc_readdata", ReadDataM, e_rd);
      chk("cyc_addr", dmem_addr, m_addr);
      chk("cyc_we", 32'(dmem_we), 32'(m_we && !reset));
      chk("cyc_wstrb", 32'(dmem_wstrb), reset ? 32'h0 : 32'(m_strb));
      if (m_we) chk("cyc_wdata", dmem_wdata, m_wdata);
    end
  end

  // ---------------- directed access driver ----------------
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                            input int ready_delay, output logic [31:0] res, output int stalls,
                            output int vcyc, output bit stable, output logic [31:0] s_addr,
                            output logic s_we, output logic [3:0] s_strb, output logic [31:0] s_wd);
    bit acc_p = 0, rsp_p = 0, done = 0;
    res = '0; stalls = 0; vcyc = 0; stable = 1;
    s_addr = '0; s_we = 0; s_strb = '0; s_wd = '0;
    @(negedge clk);
    MemReadM = rd; MemWriteM = wr; funct3M = f3; ALUResultM = a; WriteDataM = wd;
    dmem_req_ready = 0; dmem_rsp_valid = 0;
    for (int c = 0; c < 30 && !done; c++) begin
      #3;
      if (StallM) stalls++;
      if (dmem_req_valid) begin
        vcyc++;
        if (vcyc == 1) begin
          s_addr = dmem_addr; s_we = dmem_we; s_strb = dmem_wstrb; s_wd = dmem_wdata;
        end else if (s_addr !== dmem_addr || s_we !== dmem_we || s_strb !== dmem_wstrb ||
                     s_wd !== dmem_wdata) stable = 0;
      end
      dmem_req_ready = 0; dmem_rsp_valid = 0;
      if (rsp_p) begin
        res = ReadDataM; done = 1; MemReadM = 0; MemWriteM = 0;
      end else if (acc_p) begin
        dmem_rsp_valid = 1; dmem_rdata = rdat; rsp_p = 1;
      end else if (dmem_req_valid && vcyc > ready_delay) begin
        dmem_req_ready = 1; acc_p = 1;
      end
      @(negedge clk);
    end
    chk("access_completes", 32'(done), 32'h1);
    MemReadM = 0; MemWriteM = 0; dmem_req_ready = 0; dmem_rsp_valid = 0;
  endtask

  initial begin
    logic [31:0] res, sa, swd;
    logic        swe;
    logic [3:0]  sstrb;
    int          st, vc, k;
    bit          stable;

    reset = 1; MemReadM = 0; MemWriteM = 0; funct3M = 3'b010; ALUResultM = 32'h100;
    WriteDataM = 0; dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rdata = 0;
    @(negedge clk);
    cmp_en = 1;
    MemReadM = 1;
    #3;
    chk("rst_valid", 32'(dmem_req_valid), 32'h0);
    chk("rst_stall", 32'(StallM), 32'h0);
    chk("rst_readdata", ReadDataM, 32'h0);
    chk("rst_wstrb", 32'(dmem_wstrb), 32'h0);
    @(negedge clk);
    MemReadM = 0; reset = 0;

    run_access(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, res, st, vc, stable, sa, swe, sstrb, swd);
    chk("lw_data", res, 32'hDEADBEEF);
    chk("lw_stalls", 32'(st), 32'd3);
    chk("lw_requests", 32'(vc), 32'd1);
    chk("lw_addr", sa, 32'h100);
    run_access(1, 0, 3'b000, 32'h103, 0, 32'h80112233, 1, res, st, vc, stable, sa, swe, sstrb, swd);
    chk("lb_data", res, 32'hFFFFFF80);
    run_access(1, 0, 3'b100, 32'h103, 0, 32'h80112233, 0, res, st, vc, stable, sa, swe, sstrb, swd);
    chk("lbu_data", res, 32'h00000080);
    run_access(1, 0, 3'b101, 32'h102, 0, 32'h80112233, 0, res, st, vc, stable, sa, swe, sstrb, swd);
    chk("lhu_data", res, 32'h00008011);
    run_access(1, 0, 3'b001, 32'h102, 0, 32'h80112233, 0, res, st, vc, stable, sa, swe, sstrb, swd);
    chk("lh_data", res, 32'hFFFF8011);
    run_access(0, 1, 3'b000, 32'h201, 32'h000000AB, 32'h55555555, 0, res, st, vc, stable, sa, swe, sstrb, swd);
    chk("sb_addr", sa, 32'h200);
    chk("sb_we", 32'(swe), 32'h1);
    chk("sb_wstrb", 32'(sstrb), 32'h2);
    chk("sb_wdata", swd, 32'hABABABAB);
    chk("sb_readdata", res, 32'h0);
    run_access(1, 1, 3'b001, 32'h202, 32'h99991234, 0, 0, res, st, vc, stable, sa, swe, sstrb, swd);
    chk("sh_wstrb", 32'(sstrb), 32'hC);
    chk("sh_wdata", swd, 32'h12341234);
    chk("sh_we", 32'(swe), 32'h1);
    run_access(0, 1, 3'b010, 32'h304, 32'h11223344, 0, 4, res, st, vc, stable, sa, swe, sstrb, swd);
    chk("sw_req_cycles", 32'(vc), 32'd5);
    chk("sw_stalls", 32'(st), 32'd7);
    chk("sw_stable", 32'(stable), 32'h1);
    chk("sw_wstrb", 32'(sstrb), 32'hF);
    chk("sw_wdata", swd, 32'h11223344);

    // misaligned word load
    @(negedge clk);
    MemReadM = 1; funct3M = 3'b010; ALUResultM = 32'h102;
    #3;
    chk("mis_flag", 32'(MisalignM), 32'h1);
    chk("mis_valid", 32'(dmem_req_valid), 32'h0);
    chk("mis_stall", 32'(StallM), 32'h0);
    @(negedge clk);
    MemReadM = 0;
    #3;
    chk("mis_oneshot", 32'(MisalignM), 32'h0);
    chk("mis_no_req", 32'(dmem_req_valid), 32'h0);

    // reset while waiting for the response
    @(negedge clk);
    MemReadM = 1; funct3M = 3'b010; ALUResultM = 32'h100;
    @(negedge clk);
    #3;
    chk("abort_req", 32'(dmem_req_valid), 32'h1);
    dmem_req_ready = 1;
    @(negedge clk);
    dmem_req_ready = 0; reset = 1; MemReadM = 0;
    #3;
    chk("abort_rst_stall", 32'(StallM), 32'h0);
    @(negedge clk);
    reset = 0; dmem_rsp_valid = 1; dmem_rdata = 32'hCAFEF00D;
    #3;
    chk("abort_stall", 32'(StallM), 32'h0);
    chk("abort_readdata", ReadDataM, 32'h0);
    @(negedge clk);
    dmem_rsp_valid = 0;
    #3;
    chk("abort_no_done", ReadDataM, 32'h0);
    chk("abort_no_req", 32'(dmem_req_valid), 32'h0);

    // randomized traffic, bus responses unconstrained
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 99) == 0);
      k = $urandom_range(0, 5);
      MemReadM  = (k == 1 || k == 2 || k == 5);
      MemWriteM = (k == 3 || k == 4 || k == 5);
      if (MemWriteM) funct3M = 3'($urandom_range(0, 2));
      else begin
        k = $urandom_range(0, 4);
        funct3M = (k < 3) ? 3'(k) : 3'(k + 1);
      end
      ALUResultM     = 32'h1000 + 32'($urandom_range(0, 63));
      WriteDataM     = $urandom;
      dmem_req_ready = ($urandom_range(0, 2) != 0);
      dmem_rsp_valid = ($urandom_range(0, 2) == 0);
      dmem_rdata     = $urandom;
    end

    @(negedge clk);
    reset = 1; MemReadM = 0; MemWriteM = 0; dmem_req_ready = 0; dmem_rsp_valid = 0;
    repeat (2) @(negedge clk);
    #4;
    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter: XLEN, 32, datapath and address width; only 32 is supported.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 MemReadM  in  1  MEM-stage instruction is a load.
REQ-005 MemWriteM  in  1  MEM-stage instruction is a store.
REQ-006 funct3M  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 ALUResultM  in  XLEN  effective byte address from EX/MEM register.
REQ-008 WriteDataM  in  XLEN  forwarded store data from EX/MEM register.
REQ-009 dmem_req_valid  out  1  bus request valid.
REQ-010 dmem_req_ready  in  1  bus accepts request this cycle.
REQ-011 dmem_addr  out  XLEN  word-aligned address {addr[31:2],2'b00}.
REQ-012 dmem_we  out  1  1 = write, 0 = read.
REQ-013 dmem_wstrb  out  4  byte-lane write enables; 0000 on reads.
REQ-014 dmem_wdata  out  XLEN  lane-aligned store data.
REQ-015 dmem_rsp_valid  in  1  response/ack for the accepted request; read data valid.
REQ-016 dmem_rdata  in  XLEN  raw word read data.
REQ-017 ReadDataM  out  XLEN  size/sign-extended load result.
REQ-018 StallM  out  1  freeze IF/ID/EX/MEM registers this cycle.
REQ-019 MisalignM  out  1  one-cycle misaligned-access flag.

Function
REQ-020 FSM states: IDLE, REQ, WAIT, DONE; encoding is an implementation choice.
REQ-021 Access = MemReadM|MemWriteM; both high together is treated as a store.
REQ-022 Misaligned = (H/HU and addr[0]=1) or (W and addr[1:0]!=00); B/BU never misaligned.
REQ-023 IDLE, no access: StallM=0, dmem_req_valid=0, state holds.
REQ-024 IDLE, aligned access: latch address, we, wstrb, wdata, funct3, addr[1:0]; StallM=1; next state REQ.
REQ-025 IDLE, misaligned access: no bus request, MisalignM=1 that cycle, StallM=0, ReadDataM=0, state stays IDLE.
REQ-026 REQ: dmem_req_valid=1 with latched fields stable; StallM=1; on dmem_req_ready -> WAIT.
REQ-027 WAIT: dmem_req_valid=0, StallM=1; on dmem_rsp_valid capture dmem_rdata -> DONE.
REQ-028 DONE: StallM=0, ReadDataM driven from captured data (loads) or 0 (stores); next state IDLE unconditionally.
REQ-029 dmem_rsp_valid outside WAIT is ignored.
REQ-030 Store lanes: SB wstrb=0001<<a[1:0], wdata=byte replicated x4; SH wstrb=0011<<a[1:0], wdata=half replicated x2; SW wstrb=1111, wdata=WriteDataM.
REQ-031 Load extract: byte at rdata[8*a[1:0]+:8], half at rdata[16*a[1]+:16]; B/H sign-extend, BU/HU zero-extend, W passes through.
REQ-032 Minimum latency with ready and response each on the first possible cycle: access seen cycle 0, REQ cycle 1, WAIT cycle 2 (rsp), DONE cycle 3; StallM high cycles 0-2.
REQ-033 Exactly one bus request is issued per aligned access; DONE guarantees the stalled instruction is not reissued.

Reset
REQ-034 reset=1 forces state IDLE and clears latched request and captured data in the same edge.
REQ-035 While and after reset: dmem_req_valid=0, StallM=0, MisalignM=0, ReadDataM=0, dmem_we=0, dmem_wstrb=0000.
REQ-036 Reset in REQ or WAIT abandons the transaction; a later dmem_rsp_valid is ignored.

Verification
REQ-037 LW addr 0x100, ready in REQ, rsp next cycle rdata=0xDEADBEEF -> one request, StallM 3 cycles, ReadDataM=0xDEADBEEF in DONE.
REQ-038 LB addr 0x103, rdata=0x80112233 -> ReadDataM=0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x00008011.
REQ-039 SB addr 0x201, WriteDataM=0x000000AB -> dmem_addr=0x200, wstrb=0010, wdata=0xABABABAB, we=1.
REQ-040 LW addr 0x102 -> MisalignM=1 for one cycle, no dmem_req_valid, StallM=0.
REQ-041 SW with dmem_req_ready low 4 cycles -> req fields stable throughout, StallM high until DONE, single acceptance.
REQ-042 reset asserted in WAIT, rsp arrives next cycle -> state IDLE, ReadDataM=0, no DONE, StallM=0.
